// File: rtl/br_alu_mem_pkg.sv
// Shared widths and ALU opcode encodings for the br_alu_mem datapath slice.
package br_alu_mem_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef enum logic [2:0] {
    OP_DIV = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_AND = 3'b011,
    OP_MUL = 3'b100,
    OP_NOR = 3'b101,
    OP_SUB = 3'b110,
    OP_ADD = 3'b111
  } alu_op_e;

endpackage

// File: rtl/br_alu_mem_alu.sv
// Combinational ALU with zero flag. Multiply/divide exist only when
// BR_ALU_MEM_MULDIV_EN is defined; otherwise those opcodes yield zero.
module br_alu
  import br_alu_mem_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [2:0]   i_sel,
  output logic [W-1:0] o_y,
  output logic         o_zf
);

  always_comb begin
    o_y = '0;
    case (alu_op_e'(i_sel))
      OP_ADD: o_y = i_a + i_b;
      OP_SUB: o_y = i_a - i_b;
`ifdef BR_ALU_MEM_MULDIV_EN
      OP_MUL: o_y = i_a * i_b;
      // Divide by zero saturates to all ones rather than being undefined.
      OP_DIV: o_y = (i_b == '0) ? '1 : (i_a / i_b);
`else
      OP_MUL: o_y = '0;
      OP_DIV: o_y = '0;
`endif
      OP_AND: o_y = i_a & i_b;
      OP_OR:  o_y = i_a | i_b;
      OP_XOR: o_y = i_a ^ i_b;
      OP_NOR: o_y = ~(i_a | i_b);
      default: o_y = '0;
    endcase
  end

  assign o_zf = (o_y == '0);

endmodule

// File: rtl/br_alu_mem.sv
// Execute/memory slice: register bank -> ALU -> data memory, all reads
// combinational. Optional mul/div via BR_ALU_MEM_MULDIV_EN.
module br_alu_mem
#(
  parameter int DATA_W = br_alu_mem_pkg::DATA_W,
  parameter int ADDR_W = br_alu_mem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Ewr,
  input  logic [ADDR_W-1:0] Dir,
  input  logic [2:0]        Sel,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [DATA_W-1:0] Di,
  input  logic [ADDR_W-1:0] Dirr,
  input  logic              RegWrite,
  output logic              ZF,
  output logic [DATA_W-1:0] Dout
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] w_regs [DEPTH];
  logic [DATA_W-1:0] w_mem  [DEPTH];
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_y;

  // Both arrays need a full async clear, so they are built from flops
  // per entry rather than inferred RAM.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DATA_W-1:0] r_reg_word;
      logic [DATA_W-1:0] r_mem_word;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_reg_word <= '0;
        end else if (RegWrite && (Dirr == ADDR_W'(gi))) begin
          r_reg_word <= Di;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mem_word <= '0;
        end else if (Ewr && (Dir == ADDR_W'(gi))) begin
          r_mem_word <= w_y;
        end
      end

      assign w_regs[gi] = r_reg_word;
      assign w_mem[gi]  = r_mem_word;
    end
  endgenerate

  assign w_a  = w_regs[RA1];
  assign w_b  = w_regs[RA2];
  assign Dout = w_mem[Dir];

  br_alu #(
    .W(DATA_W)
  ) u_alu (
    .i_a  (w_a),
    .i_b  (w_b),
    .i_sel(Sel),
    .o_y  (w_y),
    .o_zf (ZF)
  );

endmodule

// File: tb/tb_br_alu_mem.sv
// Scoreboard bench for br_alu_mem: expected ALU results are queued when an
// op is issued with Ewr=1 and checked against Dout after the write edge.
module tb_br_alu_mem;

`ifdef BR_ALU_MEM_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Ewr;
  logic [4:0]  Dir;
  logic [2:0]  Sel;
  logic [4:0]  RA1;
  logic [4:0]  RA2;
  logic [31:0] Di;
  logic [4:0]  Dirr;
  logic        RegWrite;
  logic        ZF;
  logic [31:0] Dout;

  int errs   = 0;
  int checks = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  br_alu_mem dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Ewr     (Ewr),
    .Dir     (Dir),
    .Sel     (Sel),
    .RA1     (RA1),
    .RA2     (RA2),
    .Di      (Di),
    .Dirr    (Dirr),
    .RegWrite(RegWrite),
    .ZF      (ZF),
    .Dout    (Dout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input logic [4:0] a, input logic [31:0] v);
    RegWrite = 1'b1;
    Dirr     = a;
    Di       = v;
    tick();
    RegWrite = 1'b0;
  endtask

  task automatic store_op(input string tag, input logic [4:0] ra1, input logic [4:0] ra2,
                          input logic [2:0] sel, input logic [4:0] dir, input logic [31:0] exp_y);
    logic [31:0] e;
    RA1 = ra1; RA2 = ra2; Sel = sel; Dir = dir; Ewr = 1'b1;
    #1;
    chk({tag, "_zf"}, {31'd0, ZF}, {31'd0, (exp_y == 32'd0)});
    exp_q.push_back(exp_y);
    tick();
    Ewr = 1'b0;
    e = exp_q.pop_front();
    chk({tag, "_dout"}, Dout, e);
    $display("txn %-10s sel=%b R[%0d],R[%0d] -> M[%0d] dout=%h exp=%h", tag, sel, ra1, ra2, dir, Dout, e);
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b111: return a + b;
      3'b110: return a - b;
      3'b100: return MD ? a * b : 32'd0;
      3'b000: return MD ? ((b == 32'd0) ? 32'hFFFF_FFFF : a / b) : 32'd0;
      3'b011: return a & b;
      3'b001: return a | b;
      3'b010: return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  op;

    rst_n = 1'b0; Ewr = 1'b0; Dir = '0; Sel = 3'b111; RA1 = '0; RA2 = '0;
    Di = '0; Dirr = '0; RegWrite = 1'b0;
    #12;
    chk("rst_dout", Dout, 32'd0);
    chk("rst_zf_add", {31'd0, ZF}, 32'd1);
    Sel = 3'b000; #1;
    chk("rst_zf_div", {31'd0, ZF}, MD ? 32'd0 : 32'd1);
    Sel = 3'b101; #1;
    chk("rst_zf_nor", {31'd0, ZF}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic add path, then full op sweep on R3=350, R2=150.
    set_reg(5'd2, 32'd150);
    store_op("add", 5'd2, 5'd0, 3'b111, 5'd4, 32'd150);
    set_reg(5'd3, 32'd350);
    store_op("sub", 5'd3, 5'd2, 3'b110, 5'd10, 32'd200);
    store_op("mul", 5'd3, 5'd2, 3'b100, 5'd11, MD ? 32'd52500 : 32'd0);
    store_op("div", 5'd3, 5'd2, 3'b000, 5'd12, MD ? 32'd2 : 32'd0);
    store_op("and", 5'd3, 5'd2, 3'b011, 5'd13, 32'd22);
    store_op("or",  5'd3, 5'd2, 3'b001, 5'd14, 32'd478);
    store_op("xor", 5'd3, 5'd2, 3'b010, 5'd15, 32'd456);
    store_op("nor", 5'd3, 5'd2, 3'b101, 5'd16, 32'hFFFF_FE21);
    store_op("sub_zero", 5'd2, 5'd2, 3'b110, 5'd8, 32'd0);
    store_op("div0", 5'd3, 5'd9, 3'b000, 5'd21, MD ? 32'hFFFF_FFFF : 32'd0);

    // Memory write to a live address: old word visible until the edge.
    RA1 = 5'd2; RA2 = 5'd2; Sel = 3'b110; Dir = 5'd4; Ewr = 1'b1; #1;
    chk("mem_rdw_old", Dout, 32'd150);
    tick();
    Ewr = 1'b0;
    chk("mem_rdw_new", Dout, 32'd0);

    // Disabled writes change nothing.
    RegWrite = 1'b0; Di = 32'd250; Dirr = 5'd2;
    RA1 = 5'd3; RA2 = 5'd2; Sel = 3'b111; Dir = 5'd4; Ewr = 1'b0;
    tick();
    chk("ewr0_mem", Dout, 32'd0);
    store_op("regwr0", 5'd2, 5'd9, 3'b001, 5'd22, 32'd150);

    // Register read-during-write: operand is the old value this cycle.
    set_reg(5'd5, 32'd7);
    RegWrite = 1'b1; Dirr = 5'd5; Di = 32'd0;
    store_op("reg_rdw", 5'd5, 5'd9, 3'b001, 5'd20, 32'd7);
    RegWrite = 1'b0;
    RA1 = 5'd5; RA2 = 5'd9; Sel = 3'b001; #1;
    chk("reg_rdw_new", {31'd0, ZF}, 32'd1);

    // Randomised ops against the reference model.
    for (int i = 0; i < 12; i++) begin
      ra = $urandom();
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom() >> $urandom_range(0, 24));
      op = 3'($urandom_range(0, 7));
      set_reg(5'd10, ra);
      set_reg(5'd11, rb);
      store_op($sformatf("rnd%0d", i), 5'd10, 5'd11, op, 5'(24 + (i % 8)), model(op, ra, rb));
    end

    // Async reset mid-cycle with writes pending: everything clears at once.
    Dir = 5'd22; RegWrite = 1'b1; Dirr = 5'd1; Di = 32'd5; Ewr = 1'b1;
    RA1 = 5'd3; RA2 = 5'd9; Sel = 3'b001;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", Dout, 32'd0);
    chk("mid_rst_zf", {31'd0, ZF}, 32'd1);
    tick();
    RegWrite = 1'b0; Ewr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 32; r++) begin
      RA1 = 5'(r); RA2 = 5'(r); Sel = 3'b001; Dir = 5'(r); #1;
      chk($sformatf("rst_reg%0d", r), {31'd0, ZF}, 32'd1);
      chk($sformatf("rst_mem%0d", r), Dout, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
